// File: rtl/modexp_pkg.sv
// Shared constants and state encodings for the modexp operand/result boundary.
// State codes are visible to host software and must not be renumbered.
package modexp_pkg;

  localparam int WIDTH      = 4096;
  localparam int DATA_WIDTH = 64;
  localparam int WORDS      = WIDTH / DATA_WIDTH;
  localparam int IDX_W      = $clog2(WORDS);

  typedef enum logic [3:0] {
    IDLE          = 4'd0,
    LOAD          = 4'd1,
    LOADED        = 4'd2,
    WAIT_COMPUTE  = 4'd3,
    COMPLETE      = 4'd9,
    OUTPUT_RESULT = 4'd10
  } state_e;

endpackage

// File: rtl/modexp_word_buf.sv
// Full-width operand register written one word at a time, with synchronous clear.
module modexp_word_buf
  import modexp_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int DW = DATA_WIDTH,
  parameter int IW = IDX_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic          clr,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] din,
  output logic [W-1:0]  q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q_q <= '0;
    end else if (we) begin
      q_q[idx*DW +: DW] <= din;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/modexp_io_rx.sv
// Word-serial operand loader, core launcher and result unloader for the modexp core.
// Define MODEXP_ZEROIZE_EN to clear operands and result once the unload completes.
module modexp_io_rx
  import modexp_pkg::*;
#(
  parameter int WIDTH      = modexp_pkg::WIDTH,
  parameter int DATA_WIDTH = modexp_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  startInput,
  input  logic [DATA_WIDTH-1:0] m_buf,
  input  logic [DATA_WIDTH-1:0] e_buf,
  input  logic [DATA_WIDTH-1:0] n_buf,
  input  logic [DATA_WIDTH-1:0] r_buf,
  input  logic [DATA_WIDTH-1:0] t_buf,
  input  logic [63:0]           nprime0,
  input  logic                  startCompute,
  input  logic                  getResult,
  input  logic                  core_done,
  input  logic [WIDTH-1:0]      core_result,
  output logic [WIDTH-1:0]      m_out,
  output logic [WIDTH-1:0]      e_out,
  output logic [WIDTH-1:0]      n_out,
  output logic [WIDTH-1:0]      r_out,
  output logic [WIDTH-1:0]      t_out,
  output logic [63:0]           nprime0_out,
  output logic                  core_start,
  output logic [DATA_WIDTH-1:0] res_out,
  output logic [3:0]            state
);

  localparam int N_WORDS = WIDTH / DATA_WIDTH;
  localparam int IW      = $clog2(N_WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);
`ifdef MODEXP_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  state_e                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  core_start_q, core_start_d;
  logic [WIDTH-1:0]      result_q;
  logic [63:0]           nprime0_q;
  logic [DATA_WIDTH-1:0] res_out_q;
  logic                  res_clr_q;
  logic                  load_we, capture, unload, zeroize;

  logic [DATA_WIDTH-1:0] op_din [5];
  logic [WIDTH-1:0]      op_q   [5];
  logic [DATA_WIDTH-1:0] res_words [N_WORDS];

  assign op_din = '{m_buf, e_buf, n_buf, r_buf, t_buf};

  for (genvar gi = 0; gi < 5; gi++) begin : g_op
    modexp_word_buf #(
      .W (WIDTH),
      .DW(DATA_WIDTH),
      .IW(IW)
    ) u_buf (
      .clk  (clk),
      .reset(reset),
      .we   (load_we),
      .clr  (zeroize),
      .idx  (idx_q),
      .din  (op_din[gi]),
      .q    (op_q[gi])
    );
  end

  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_res
    assign res_words[gi] = result_q[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    core_start_d = 1'b0;
    load_we      = 1'b0;
    capture      = 1'b0;
    unload       = 1'b0;
    zeroize      = 1'b0;
    case (state_q)
      IDLE: if (startInput) begin
        state_d = LOAD;
        idx_d   = '0;
      end
      LOAD: begin
        load_we = 1'b1;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) state_d = LOADED;
      end
      LOADED: if (startCompute) begin
        state_d      = WAIT_COMPUTE;
        core_start_d = 1'b1;
      end
      WAIT_COMPUTE: if (core_done) begin
        state_d = COMPLETE;
        capture = 1'b1;
      end
      COMPLETE: if (getResult) begin
        state_d = OUTPUT_RESULT;
        idx_d   = '0;
      end
      OUTPUT_RESULT: begin
        unload = 1'b1;
        idx_d  = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          zeroize = ZEROIZE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      core_start_q <= 1'b0;
      result_q     <= '0;
      nprime0_q    <= '0;
      res_out_q    <= '0;
      res_clr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      core_start_q <= core_start_d;
      // res_out keeps the last word one extra cycle before a zeroize clear lands.
      res_clr_q    <= zeroize;
      if (capture) result_q <= core_result;
      else if (zeroize) result_q <= '0;
      if (load_we && idx_q == LAST_IDX) nprime0_q <= nprime0;
      else if (zeroize) nprime0_q <= '0;
      if (unload) res_out_q <= res_words[idx_q];
      else if (res_clr_q) res_out_q <= '0;
    end
  end

  assign m_out       = op_q[0];
  assign e_out       = op_q[1];
  assign n_out       = op_q[2];
  assign r_out       = op_q[3];
  assign t_out       = op_q[4];
  assign nprime0_out = nprime0_q;
  assign core_start  = core_start_q;
  assign res_out     = res_out_q;
  assign state       = state_q;

endmodule

// File: doc/modexp_io_rx.md
# modexp_io_rx

Word-serial operand receiver and result transmitter at the boundary of the 4096-bit Montgomery modular-exponentiation core. It is the core-side end of the host load/unload protocol. It deserializes 64 words of 64 bits for each of m, e, n, r and t, plus nprime0, into full-width operand registers. It then starts the core, captures the finished result, and streams it back out one word per cycle on res_out.

## Interface
Parameters:
- WIDTH, 4096, operand width in bits
- DATA_WIDTH, 64, word width; WORDS = WIDTH/DATA_WIDTH (64)

Ports (clock and reset first):
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high; clock clk
- startInput  in  1  level; begins operand load when sampled high in IDLE
- m_buf, e_buf, n_buf, r_buf, t_buf  in  DATA_WIDTH  operand words, LSW first
- nprime0  in  64  -n^-1 mod 2^64
- startCompute  in  1  level; launches core from LOADED
- getResult  in  1  level; begins result unload from COMPLETE
- core_done  in  1  one-cycle pulse from core
- core_result  in  WIDTH  core result, valid with core_done
- m_out, e_out, n_out, r_out, t_out  out  WIDTH  operand registers to core
- nprime0_out  out  64  registered nprime0
- core_start  out  1  one-cycle pulse to core
- res_out  out  DATA_WIDTH  registered result word
- state  out  4  current state encoding

## Operation
State encodings, shared with host software and benches:
- IDLE=0, LOAD=1, LOADED=2, WAIT_COMPUTE=3, COMPLETE=9, OUTPUT_RESULT=10
- All other codes are illegal and return to IDLE on the next edge.

Transitions:
- IDLE: startInput=1 → LOAD, idx<=0.
- LOAD: every edge writes word idx of each operand, bits idx*64 +: 64, from *_buf; then idx++. The edge that writes idx=63 also captures nprime0, then → LOADED.
- LOADED: startCompute=1 → WAIT_COMPUTE; core_start=1 for exactly that one edge.
- WAIT_COMPUTE: core_done=1 → result_reg<=core_result, → COMPLETE.
- COMPLETE: getResult=1 → OUTPUT_RESULT, idx<=0.
- OUTPUT_RESULT: every edge does res_out<=result_reg[idx*64 +: 64], then idx++. The edge that loads idx=63 → IDLE.
- idx is a 6-bit counter. It wraps only by state exit and never indexes past 63.

Ignored inputs:
- startInput outside IDLE.
- startCompute outside LOADED.
- getResult outside COMPLETE.
- core_done outside WAIT_COMPUTE.
- Inputs are not queued.

Other rules:
- If startInput is still high when IDLE is re-entered after an unload, a new load begins on the next edge. This is intended.
- Operand registers hold their values through WAIT_COMPUTE. The core reads them directly.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, idx=0, all operand/result registers=0, nprime0_out=0, res_out=0, core_start=0.
- Load: entry edge E0 (IDLE→LOAD). Word k is sampled at edge E(k+1); k=63 is sampled at E64 together with the LOADED transition. The host must present word k during the cycle preceding E(k+1). There is no per-word valid.
- Compute start: core_start is high for the single cycle after the LOADED→WAIT_COMPUTE edge.
- Capture: core_result is latched on the same edge core_done is sampled high.
- Unload: entry edge U0. res_out shows word k from edge U(k+1) until U(k+2). Word 63 remains on res_out after returning to IDLE, until the next unload or reset.
- Reset mid-operation, in any state: abandon immediately on that edge and apply reset values. A partially loaded operand is discarded.
- Simultaneous reset and any handshake: reset wins.

## Configuration
- MODEXP_ZEROIZE_EN defined: the edge completing OUTPUT_RESULT also clears all operand registers, nprime0_out and result_reg to 0. res_out still holds word 63 for one further cycle, then clears to 0.
- Not defined: operand and result registers retain their values until overwritten or reset.

## Structure
- Package modexp_pkg holds: the state encodings above, DATA_WIDTH, WIDTH, WORDS, and the idx width localparam.
- Sub-module modexp_word_buf: a WIDTH-bit register with a word-indexed write port (we, idx, din) and optional synchronous clear. It is instantiated five times, once per operand.
- Result unload uses a word-indexed read mux on result_reg inside the top module.

## Test plan
- Nominal: m=8, e=13, n=77, r, t arbitrary; core model returns 8^13 mod 77 = 50 after 100 cycles. Expect state sequence 0→1→2→3→9→10→0, and res_out word 0 = 50 with words 1..63 = 0.
- Word ordering: load m with word k = k+1. Expect m_out[k*64 +: 64] = k+1 for every k, and nprime0_out equal to the value driven at E64.
- Handshake filtering: pulse getResult in LOADED and startCompute in WAIT_COMPUTE. Expect no state change; core_start is high for exactly one cycle total.
- Reset at LOAD word 30: expect state=0 and m_out=0 next cycle. A full reload then produces correct operands.
- Back-to-back with startInput held high: after unload, expect LOAD entered on the edge after IDLE is reached, and the second result correct.
- With MODEXP_ZEROIZE_EN: after unload, expect all *_out=0 and, one cycle after word 63 was shown, res_out=0. Without the macro, expect the operands retained.
